// File: rtl/ps2_scancode_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_rx
// Brief    : PS/2 keyboard receiver: clock filter, 11-bit frame deserialiser,
//            E0/F0 prefix folding and a first-word-fall-through code FIFO.
//            Define PS2_SCANCODE_HEX_EN to add the hex-digit decode ports.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clock,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    code_data,
    output logic                          code_ext,
    output logic                          code_break,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          err_valid,
    output logic [1:0]                    err_code
`ifdef PS2_SCANCODE_HEX_EN
    ,
    output logic                          hex_valid,
    output logic [3:0]                    hex_value
`endif
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT_CYCLES - 1);
    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    // ------------------------------------------------------------------------
    // Synchronisers and clock filter
    // ------------------------------------------------------------------------
    logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  filt_clk_q, filt_clk_d;
    logic                  strobe;

    always_comb begin
        filt_sr_d = {filt_sr_q[FILTER_LEN-2:0], clk_s2_q};
        if (&filt_sr_q)
            filt_clk_d = 1'b1;
        else if (~|filt_sr_q)
            filt_clk_d = 1'b0;
        else
            filt_clk_d = filt_clk_q;
        strobe = filt_clk_q & ~filt_clk_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_sr_q  <= '1;
            filt_clk_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clock;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            filt_sr_q  <= filt_sr_d;
            filt_clk_q <= filt_clk_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM, timeout and prefix folding
    // ------------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [2:0]      bcnt_q, bcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_ok_q, par_ok_d;
    logic [c_tw-1:0] tmo_q, tmo_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            push;
    logic [9:0]      push_word;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        par_ok_d    = par_ok_q;
        tmo_d       = tmo_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        push        = 1'b0;
        push_word   = {ext_q, brk_q, shreg_q};

        case (state_q)
            c_st_idle: begin
                if (strobe && !dat_s2_q) begin
                    state_d = c_st_data;
                    bcnt_d  = 3'd0;
                end
            end
            c_st_data: begin
                if (strobe) begin
                    shreg_d = {dat_s2_q, shreg_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7)
                        state_d = c_st_parity;
                end
            end
            c_st_parity: begin
                if (strobe) begin
                    par_ok_d = ^{shreg_q, dat_s2_q};
                    state_d  = c_st_stop;
                end
            end
            default: begin
                if (strobe) begin
                    state_d = c_st_idle;
                    if (!par_ok_q || !dat_s2_q) begin
                        // Parity failure is reported even when the stop bit is also bad.
                        err_valid_d = 1'b1;
                        err_code_d  = !par_ok_q ? 2'b01 : 2'b10;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (shreg_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shreg_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end
        endcase

        // A strobe arriving on the expiry cycle keeps the frame alive.
        if (state_q == c_st_idle || strobe) begin
            tmo_d = '0;
        end else if (tmo_q == c_tmo_last) begin
            tmo_d       = '0;
            state_d     = c_st_idle;
            err_valid_d = 1'b1;
            err_code_d  = 2'b11;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= c_st_idle;
            bcnt_q      <= 3'd0;
            shreg_q     <= 8'h00;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    // ------------------------------------------------------------------------
    // First-word-fall-through FIFO
    // ------------------------------------------------------------------------
    logic [9:0]      mem [FIFO_DEPTH];
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]   count_q, count_d;
    logic [9:0]      last_q, last_d;
    logic            overflow_q, overflow_d;
    logic            pop, wr, full;
    logic [9:0]      head;

    always_comb begin
        full       = (count_q == c_depth);
        pop        = rd_en && (count_q != '0);
        wr         = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = wr  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_d     = pop ? mem[rd_ptr_q] : last_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr)
            mem[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= 10'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    // With the FIFO empty the outputs keep showing the most recently popped entry.
    assign head       = (count_q == '0) ? last_q : mem[rd_ptr_q];
    assign code_data  = head[7:0];
    assign code_break = head[8];
    assign code_ext   = head[9];
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;

`ifdef PS2_SCANCODE_HEX_EN
    logic       hex_hit;
    logic [3:0] hex_dig;

    always_comb begin
        hex_hit = 1'b1;
        hex_dig = 4'h0;
        case (head[7:0])
            8'h45: hex_dig = 4'h0;
            8'h16: hex_dig = 4'h1;
            8'h1E: hex_dig = 4'h2;
            8'h26: hex_dig = 4'h3;
            8'h25: hex_dig = 4'h4;
            8'h2E: hex_dig = 4'h5;
            8'h36: hex_dig = 4'h6;
            8'h3D: hex_dig = 4'h7;
            8'h3E: hex_dig = 4'h8;
            8'h46: hex_dig = 4'h9;
            8'h1C: hex_dig = 4'hA;
            8'h32: hex_dig = 4'hB;
            8'h21: hex_dig = 4'hC;
            8'h23: hex_dig = 4'hD;
            8'h24: hex_dig = 4'hE;
            8'h2B: hex_dig = 4'hF;
            default: hex_hit = 1'b0;
        endcase
    end

    assign hex_valid = hex_hit && !fifo_empty && !head[8] && !head[9];
    assign hex_value = hex_valid ? hex_dig : 4'h0;
`endif

endmodule
`default_nettype wire

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Synthesizable PS/2 keyboard receiver and scan-code front end; replaces ad-hoc PS/2 sampling inside top-level projects.
- Sits between the ps2_clock/ps2_data pins and the keypad/command logic (hex entry, command keys).
- Filters the PS/2 clock and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
- Folds E0/F0 prefixes into flags and buffers decoded codes in a parametrised FIFO, with error and timeout reporting.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clock changes level (>=2)
TIMEOUT_CYCLES, 100000, max system cycles between falling edges inside a frame (2 ms at 50 MHz)
FIFO_DEPTH, 4, decoded-code FIFO entries; power of two, >=2

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_clock  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
rd_en  in  1  pop FIFO head this cycle
code_data  out  8  head scan code (first-word fall-through)
code_ext  out  1  head entry was preceded by E0
code_break  out  1  head entry was preceded by F0 (key release)
fifo_empty  out  1  FIFO holds no entries
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  one-cycle pulse: a code was dropped because the FIFO was full
err_valid  out  1  one-cycle pulse: frame aborted
err_code  out  2  01 parity, 10 stop bit, 11 timeout; held until next error

Behaviour:
- Reset (async, active-high) values: fifo_empty=1, fifo_count=0, code_data/code_ext/code_break=0, overflow=0, err_valid=0, err_code=00. FSM goes to IDLE; prefix flags, filter and counters clear. Reset mid-frame discards the partial frame.
- Both pins pass through 2-FF synchronisers. The filter shift register is preset to all-ones.
- The filtered clock changes level only when all FILTER_LEN samples agree. A filtered 1->0 transition produces a one-cycle strobe.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with data=0, go to DATA with bit count 0. A strobe with data=1 is ignored.
  - DATA: each strobe shifts data into bit 7 of the shift register (LSB-first). After the 8th bit, go to PARITY.
  - PARITY: on strobe, latch parity_ok = ^{byte,bit}. Go to STOP.
  - STOP: on strobe, go to IDLE. If data=1 and parity_ok, the frame is complete. Bad parity gives error 01 (precedence over stop error). Data=0 with good parity gives error 10.
- Timeout:
  - The counter clears on every strobe and counts while not in IDLE.
  - On reaching TIMEOUT_CYCLES: err 11 and return to IDLE.
  - A timeout coinciding with a strobe: the strobe wins.
- Every error pulses err_valid, updates err_code, clears both prefix flags and pushes nothing.
- Completed byte handling:
  - E0: set ext flag. F0: set break flag. No push for either.
  - Any other byte: push {ext, break, byte} and clear both flags.
- Push timing:
  - The push is written on the clock edge after the stop strobe.
  - fifo_empty/fifo_count update on that same edge, so the head is visible one cycle after the strobe.
- FIFO is first-word fall-through:
  - code_* shows the head whenever fifo_empty=0. When empty, code_* holds the last popped value.
  - rd_en while empty is ignored.
  - Push while full (no pop that cycle): new entry dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow, count unchanged.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: PS2_SCANCODE_HEX_EN.
- Defined:
  - Adds ports hex_valid (out 1) and hex_value (out 4), combinational from the FIFO head.
  - hex_valid=1 when !fifo_empty, !code_break, !code_ext and code_data is a set-2 make code for 0-9/A-F: 45,16,1E,26,25,2E,36,3D,3E,46,1C,32,21,23,24,2B map to 0..F.
  - hex_value=0 when hex_valid=0.
- Not defined: ports and decode logic absent; the remaining behaviour is identical.

Test Plan:
- Send frame 0x1C (PS/2 half-period 1000 clock cycles, FILTER_LEN=8) -> one cycle after the stop strobe: fifo_empty=0, code_data=1C, ext=0, break=0, count=1. With the macro: hex_valid=1, hex_value=A. rd_en -> empty.
- Send F0,16 then E0,75 -> two entries: {0,1,16} then {1,0,75}. No entries for the prefixes. hex_valid=0 for both.
- Send 0x26 with the parity bit inverted -> err_valid pulse, err_code=01, FIFO empty. Next valid frame 0x1E -> code_data=1E.
- Send start + 4 data bits, then hold ps2_clock high -> after TIMEOUT_CYCLES: err_code=11, FSM IDLE. A subsequent 0x45 frame is received correctly.
- FIFO_DEPTH=4: send 16,1E,26,25,2E without reads -> overflow pulse on the 5th. Pops return 16,1E,26,25. Also push+pop in the same cycle at full -> count stays 4.
- Assert reset during bit 5 of a frame, release, send 0x3D -> all outputs at reset values, then single entry 3D. No error pulse.
